rat_pc_stack: RTL and testbench
===============================

# rat_pc_stack

Parametrised program-counter unit for the next-generation RAT MCU. It replaces the bare program counter and its PC-input mux with a single registered block. The block adds a hardware return-address stack for CALL/RET, an interrupt entry path and stack fault reporting. It sits between the control unit (which drives the one-hot-by-priority command strobes) and the program ROM address input.

## Interface
- AW, 10: PC / address width in bits
- DEPTH, 16: return-stack entries, DEPTH >= 2
- RESET_VEC, 0: PC value after reset and after RET underflow
- INTR_VEC, 2**AW-1: interrupt entry address (0x3FF at default AW)

- CLK  in  1  system clock, all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- DIN  in  AW  branch/call target from the instruction immediate field
- PC_INC  in  1  advance PC by one
- PC_LD  in  1  jump: load DIN
- CALL  in  1  push PC+1, load DIN
- RET  in  1  pop top of stack into PC
- INTR  in  1  interrupt entry: push PC_COUNT, load INTR_VEC
- ERR_CLR  in  1  clear sticky STK_ERR
- PC_COUNT  out  AW  current program counter, registered
- SP_DEPTH  out  $clog2(DEPTH+1)  number of valid stack entries
- STK_FULL  out  1  SP_DEPTH == DEPTH
- STK_EMPTY  out  1  SP_DEPTH == 0
- STK_ERR  out  1  sticky overflow/underflow flag

## Operation
- Only one command acts per cycle. Fixed priority: INTR > RET > CALL > PC_LD > PC_INC. Lower-priority strobes asserted in the same cycle are ignored.
- No command asserted: PC_COUNT holds.
- PC_INC: PC_COUNT <= PC_COUNT+1, modulo 2**AW. 2**AW-1 wraps to 0.
- PC_LD: PC_COUNT <= DIN. Stack untouched.
- CALL: stack[SP_DEPTH] <= PC_COUNT+1 (mod 2**AW); SP_DEPTH+1; PC_COUNT <= DIN.
- INTR: stack[SP_DEPTH] <= PC_COUNT (the not-yet-executed instruction); SP_DEPTH+1; PC_COUNT <= INTR_VEC.
- RET: PC_COUNT <= stack[SP_DEPTH-1]; SP_DEPTH-1.
- Overflow (CALL or INTR while STK_FULL):
  - jump to DIN / INTR_VEC still taken
  - push discarded, stack contents and SP_DEPTH unchanged
  - STK_ERR <= 1
- Underflow (RET while STK_EMPTY):
  - PC_COUNT <= RESET_VEC
  - SP_DEPTH stays 0
  - STK_ERR <= 1
- STK_ERR is sticky. ERR_CLR clears it. A new fault in the same cycle as ERR_CLR wins, so STK_ERR stays 1.
- Stack storage is a register array, LIFO, indexed by SP_DEPTH. No read-before-write hazard: each cycle performs one push or one pop, never both.
- STK_FULL and STK_EMPTY are combinational decodes of the SP_DEPTH register.

## Timing
- Reset values (RESET_N low, asynchronous):
  - PC_COUNT = RESET_VEC
  - SP_DEPTH = 0
  - STK_EMPTY = 1
  - STK_FULL = 0
  - STK_ERR = 0
- Stack array contents are not reset. They are don't-care until written.
- Reset asserted mid-CALL/RET: all state is forced to reset values immediately. The in-flight command is lost.
- Release of RESET_N is synchronised by the system. The first command is accepted on the first rising edge with RESET_N high.
- Latency: a command sampled at edge N is visible on PC_COUNT, SP_DEPTH, flags and STK_ERR after edge N. Command-to-output latency is 1 cycle.
- Back-to-back commands every cycle are supported. For example, CALL then RET in consecutive cycles returns to the CALL address+1 with SP_DEPTH back to its original value.
- PC_COUNT drives the synchronous program ROM directly. Instruction fetch latency is owned by the control unit's fetch state.

## Test plan
- Reset/increment: release reset, PC_INC for 3 cycles. Then force PC_COUNT to 0x3FF via PC_LD, then PC_INC -> PC_COUNT 0,1,2,3; after 0x3FF the increment wraps to 0x000; SP_DEPTH stays 0.
- Nested call/return: PC=0x010; CALL DIN=0x100; CALL DIN=0x200; RET; RET -> PC 0x100, 0x200, 0x101, 0x011; SP_DEPTH 1,2,1,0; STK_ERR 0.
- Interrupt entry: PC=0x055, assert INTR together with CALL and PC_INC -> PC 0x3FF, stack top 0x055, SP_DEPTH 1. Then RET -> PC 0x055.
- Overflow: 16 CALLs fill the stack (STK_FULL=1). A 17th CALL DIN=0x0AA -> PC 0x0AA, SP_DEPTH 16, STK_ERR 1. 16 RETs then return the original 16 addresses in reverse order.
- Underflow and error clear: RET with empty stack -> PC RESET_VEC, STK_ERR 1. ERR_CLR alone -> STK_ERR 0. ERR_CLR with a simultaneous empty RET -> STK_ERR stays 1.
- Async reset mid-operation: SP_DEPTH=3, drop RESET_N between edges -> PC_COUNT, SP_DEPTH and STK_ERR go to reset values before the next edge. Commands held during reset have no effect.

Source files
------------

// File: rtl/rat_pc_stack_if.sv
// rat_pc_stack_if: command strobes, jump target and PC/stack status of the PC unit
interface rat_pc_stack_if #(
   parameter int AW    = 10,
   parameter int DEPTH = 16
);
   localparam int SW = $clog2(DEPTH + 1);
   logic [AW-1:0] din;
   logic          pc_inc;
   logic          pc_ld;
   logic          call;
   logic          ret;
   logic          intr;
   logic          err_clr;
   logic [AW-1:0] pc_count;
   logic [SW-1:0] sp_depth;
   logic          stk_full;
   logic          stk_empty;
   logic          stk_err;
   modport master (
      output din, pc_inc, pc_ld, call, ret, intr, err_clr,
      input  pc_count, sp_depth, stk_full, stk_empty, stk_err
   );
   modport slave (
      input  din, pc_inc, pc_ld, call, ret, intr, err_clr,
      output pc_count, sp_depth, stk_full, stk_empty, stk_err
   );
endinterface

// File: rtl/rat_pc_stack.sv
// rat_pc_stack: program counter with prioritised jump/call/return/interrupt and LIFO return stack
module rat_pc_stack #(
   parameter int            AW        = 10,
   parameter int            DEPTH     = 16,
   parameter logic [AW-1:0] RESET_VEC = '0,
   parameter logic [AW-1:0] INTR_VEC  = '1
) (
   input logic           clk,
   input logic           rst_n,
   rat_pc_stack_if.slave bus
);
   localparam int SW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);
   logic [AW-1:0] pc_q, pc_d;
   logic [SW-1:0] sp_q, sp_d;
   logic          err_q, err_d;
   logic [AW-1:0] stk_q [DEPTH];
   logic          full, empty, push, pop, fault;
   logic [AW-1:0] push_val;
   logic [IW-1:0] wr_idx, rd_idx;
   // INTR outranks everything, so push/pop are mutually exclusive by construction
   always_comb begin
      full     = sp_q == SW'(DEPTH);
      empty    = sp_q == '0;
      push     = bus.intr | (~bus.ret & bus.call);
      pop      = ~bus.intr & bus.ret;
      push_val = bus.intr ? pc_q : pc_q + 1'b1;
      fault    = (push & full) | (pop & empty);
      wr_idx   = IW'(sp_q);
      rd_idx   = IW'(sp_q - 1'b1);
      pc_d     = bus.intr                ? INTR_VEC :
                 bus.ret                 ? (empty ? RESET_VEC : stk_q[rd_idx]) :
                 (bus.call | bus.pc_ld)  ? bus.din :
                 bus.pc_inc              ? pc_q + 1'b1 : pc_q;
      sp_d     = (push & ~full)  ? sp_q + 1'b1 :
                 (pop & ~empty)  ? sp_q - 1'b1 : sp_q;
      err_d    = fault | (err_q & ~bus.err_clr);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_VEC;
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end
   // Storage is deliberately not reset; entries above sp_q are never read
   always_ff @(posedge clk) begin
      if (push & ~full) stk_q[wr_idx] <= push_val;
   end
   assign bus.pc_count  = pc_q;
   assign bus.sp_depth  = sp_q;
   assign bus.stk_full  = full;
   assign bus.stk_empty = empty;
   assign bus.stk_err   = err_q;
endmodule

// File: tb/tb_rat_pc_stack.sv
// tb_rat_pc_stack: randomized and directed checks against a queue-based return-stack model
module tb_rat_pc_stack;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   rat_pc_stack_if #(.AW(10), .DEPTH(16)) bus ();
   rat_pc_stack #(.AW(10), .DEPTH(16), .RESET_VEC(10'h000), .INTR_VEC(10'h3FF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;

   logic [9:0] m_pc;
   logic [9:0] m_stk[$];
   bit         m_err;

   task automatic model_reset();
      m_pc  = 10'h000;
      m_stk.delete();
      m_err = 1'b0;
   endtask

   task automatic idle_inputs();
      bus.din = '0; bus.pc_inc = 0; bus.pc_ld = 0; bus.call = 0;
      bus.ret = 0; bus.intr = 0; bus.err_clr = 0;
   endtask

   // One clock with the given strobes, then advance the reference model
   task automatic drive(input bit intr, ret, call, ld, inc, clr, input logic [9:0] din);
      bit fault = 0;
      bus.intr = intr; bus.ret = ret; bus.call = call; bus.pc_ld = ld;
      bus.pc_inc = inc; bus.err_clr = clr; bus.din = din;
      @(posedge clk);
      #1;
      idle_inputs();
      if (intr) begin
         if (m_stk.size() == 16) fault = 1; else m_stk.push_back(m_pc);
         m_pc = 10'h3FF;
      end else if (ret) begin
         if (m_stk.size() == 0) begin fault = 1; m_pc = 10'h000; end
         else m_pc = m_stk.pop_back();
      end else if (call) begin
         if (m_stk.size() == 16) fault = 1; else m_stk.push_back(m_pc + 10'd1);
         m_pc = din;
      end else if (ld) m_pc = din;
      else if (inc) m_pc = m_pc + 10'd1;
      m_err = fault | (m_err & !clr);
   endtask

   task automatic test_reset();
      idle_inputs();
      model_reset();
      rst_n = 1'b0;
      #12;
      checks += 5;
      if (bus.pc_count !== 10'h000) begin errors++; $display("FAIL reset_pc: got %h want 000", bus.pc_count); end
      if (bus.sp_depth !== 5'd0) begin errors++; $display("FAIL reset_sp: got %0d want 0", bus.sp_depth); end
      if (bus.stk_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.stk_empty); end
      if (bus.stk_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.stk_full); end
      if (bus.stk_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.stk_err); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_increment();
      logic [9:0] exp_pc[4] = '{10'h001, 10'h002, 10'h003, 10'h000};
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 1, 0, 10'h0);
         checks++;
         if (bus.pc_count !== exp_pc[i]) begin errors++; $display("FAIL inc_%0d: got %h want %h", i, bus.pc_count, exp_pc[i]); end
      end
      drive(0, 0, 0, 1, 0, 0, 10'h3FF);
      checks++;
      if (bus.pc_count !== 10'h3FF) begin errors++; $display("FAIL ld_3ff: got %h want 3ff", bus.pc_count); end
      drive(0, 0, 0, 0, 1, 0, 10'h0);
      checks += 2;
      if (bus.pc_count !== exp_pc[3]) begin errors++; $display("FAIL inc_wrap: got %h want 000", bus.pc_count); end
      if (bus.sp_depth !== 5'd0) begin errors++; $display("FAIL inc_sp: got %0d want 0", bus.sp_depth); end
   endtask

   task automatic test_nested_call();
      logic [9:0] exp_pc[4] = '{10'h100, 10'h200, 10'h101, 10'h011};
      logic [4:0] exp_sp[4] = '{5'd1, 5'd2, 5'd1, 5'd0};
      drive(0, 0, 0, 1, 0, 0, 10'h010);
      for (int i = 0; i < 4; i++) begin
         if (i < 2) drive(0, 0, 1, 0, 0, 0, i == 0 ? 10'h100 : 10'h200);
         else drive(0, 1, 0, 0, 0, 0, 10'h0);
         checks += 3;
         if (bus.pc_count !== exp_pc[i]) begin errors++; $display("FAIL nest_pc_%0d: got %h want %h", i, bus.pc_count, exp_pc[i]); end
         if (bus.sp_depth !== exp_sp[i]) begin errors++; $display("FAIL nest_sp_%0d: got %0d want %0d", i, bus.sp_depth, exp_sp[i]); end
         if (bus.stk_err !== 1'b0) begin errors++; $display("FAIL nest_err_%0d: got %b want 0", i, bus.stk_err); end
      end
   endtask

   task automatic test_interrupt();
      drive(0, 0, 0, 1, 0, 0, 10'h055);
      drive(1, 0, 1, 0, 1, 0, 10'h123);
      checks += 2;
      if (bus.pc_count !== 10'h3FF) begin errors++; $display("FAIL intr_pc: got %h want 3ff", bus.pc_count); end
      if (bus.sp_depth !== 5'd1) begin errors++; $display("FAIL intr_sp: got %0d want 1", bus.sp_depth); end
      drive(0, 1, 0, 0, 0, 0, 10'h0);
      checks += 2;
      if (bus.pc_count !== 10'h055) begin errors++; $display("FAIL intr_ret_pc: got %h want 055", bus.pc_count); end
      if (bus.sp_depth !== 5'd0) begin errors++; $display("FAIL intr_ret_sp: got %0d want 0", bus.sp_depth); end
   endtask

   task automatic test_overflow();
      logic [9:0] ret_addr[16];
      logic [9:0] d;
      drive(0, 0, 0, 0, 0, 1, 10'h0);
      for (int i = 0; i < 16; i++) begin
         ret_addr[i] = m_pc + 10'd1;
         d = 10'($urandom_range(0, 1023));
         drive(0, 0, 1, 0, 0, 0, d);
      end
      checks += 2;
      if (bus.stk_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", bus.stk_full); end
      if (bus.stk_err !== 1'b0) begin errors++; $display("FAIL ovf_err_pre: got %b want 0", bus.stk_err); end
      drive(0, 0, 1, 0, 0, 0, 10'h0AA);
      checks += 3;
      if (bus.pc_count !== 10'h0AA) begin errors++; $display("FAIL ovf_pc: got %h want 0aa", bus.pc_count); end
      if (bus.sp_depth !== 5'd16) begin errors++; $display("FAIL ovf_sp: got %0d want 16", bus.sp_depth); end
      if (bus.stk_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", bus.stk_err); end
      for (int i = 15; i >= 0; i--) begin
         drive(0, 1, 0, 0, 0, 0, 10'h0);
         checks++;
         if (bus.pc_count !== ret_addr[i]) begin errors++; $display("FAIL ovf_ret_%0d: got %h want %h", i, bus.pc_count, ret_addr[i]); end
      end
      checks++;
      if (bus.stk_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b want 1", bus.stk_empty); end
   endtask

   task automatic test_underflow_clear();
      drive(0, 0, 0, 1, 0, 0, 10'h2A5);
      drive(0, 1, 0, 0, 0, 1, 10'h0);
      checks += 3;
      if (bus.pc_count !== 10'h000) begin errors++; $display("FAIL unf_pc: got %h want 000", bus.pc_count); end
      if (bus.stk_err !== 1'b1) begin errors++; $display("FAIL unf_err: got %b want 1", bus.stk_err); end
      if (bus.sp_depth !== 5'd0) begin errors++; $display("FAIL unf_sp: got %0d want 0", bus.sp_depth); end
      drive(0, 0, 0, 0, 0, 1, 10'h0);
      checks++;
      if (bus.stk_err !== 1'b0) begin errors++; $display("FAIL clr_err: got %b want 0", bus.stk_err); end
      drive(0, 1, 0, 0, 0, 1, 10'h0);
      checks++;
      if (bus.stk_err !== 1'b1) begin errors++; $display("FAIL clr_fault_wins: got %b want 1", bus.stk_err); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 0, 10'(9'h40 * (i + 1)));
      checks += 2;
      if (bus.sp_depth !== 5'd3) begin errors++; $display("FAIL ar_sp_pre: got %0d want 3", bus.sp_depth); end
      if (bus.stk_err !== 1'b1) begin errors++; $display("FAIL ar_err_pre: got %b want 1", bus.stk_err); end
      @(negedge clk);
      bus.call = 1'b1; bus.din = 10'h155;
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (bus.pc_count !== 10'h000) begin errors++; $display("FAIL ar_pc: got %h want 000", bus.pc_count); end
      if (bus.sp_depth !== 5'd0) begin errors++; $display("FAIL ar_sp: got %0d want 0", bus.sp_depth); end
      if (bus.stk_err !== 1'b0) begin errors++; $display("FAIL ar_err: got %b want 0", bus.stk_err); end
      @(posedge clk);
      #1;
      checks += 2;
      if (bus.pc_count !== 10'h000) begin errors++; $display("FAIL ar_hold_pc: got %h want 000", bus.pc_count); end
      if (bus.sp_depth !== 5'd0) begin errors++; $display("FAIL ar_hold_sp: got %0d want 0", bus.sp_depth); end
      idle_inputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 1, 0, 10'h0);
      checks++;
      if (bus.pc_count !== 10'h001) begin errors++; $display("FAIL ar_first_cmd: got %h want 001", bus.pc_count); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 9) == 0,
               10'($urandom_range(0, 1023)));
         checks += 5;
         if (bus.pc_count !== m_pc) begin errors++; $display("FAIL rnd_pc_%0d: got %h want %h", n, bus.pc_count, m_pc); end
         if (bus.sp_depth !== 5'(m_stk.size())) begin errors++; $display("FAIL rnd_sp_%0d: got %0d want %0d", n, bus.sp_depth, m_stk.size()); end
         if (bus.stk_full !== (m_stk.size() == 16)) begin errors++; $display("FAIL rnd_full_%0d: got %b", n, bus.stk_full); end
         if (bus.stk_empty !== (m_stk.size() == 0)) begin errors++; $display("FAIL rnd_empty_%0d: got %b", n, bus.stk_empty); end
         if (bus.stk_err !== m_err) begin errors++; $display("FAIL rnd_err_%0d: got %b want %b", n, bus.stk_err, m_err); end
      end
   endtask

   initial begin
      test_reset();
      test_increment();
      test_nested_call();
      test_interrupt();
      test_overflow();
      test_underflow_clear();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
